// File: rtl/percept_bus_ctrl.sv
// rtl/percept_bus_ctrl.sv - round-robin serial bus master for the perceptron node link
module percept_bus_ctrl #(
  parameter int TIMEOUT = 256,
  parameter int GAP     = 4
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic [3:0]   req,
  input  logic [31:0]  req_addr,
  input  logic [11:0]  req_op,
  input  logic [247:0] req_data,
  output logic [3:0]   gnt,
  output logic [3:0]   done,
  output logic [7:0]   rsp_addr,
  output logic [2:0]   rsp_op,
  output logic [61:0]  rsp_data,
  output logic         rsp_err,
  output logic         busy,
  output logic         tx,
  input  logic         rx
);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_RSP, S_RECV, S_GAP} state_t;

  localparam int CW = 16;
  // SEND: counter 0..72 emits the 73 payload bits, 73 is the last frame bit-time
  localparam logic [CW-1:0] C_SEND_END = CW'(73);
  // RECV: counter 0..72 takes the 73 payload samples after the start bit
  localparam logic [CW-1:0] C_RECV_END = CW'(72);
  localparam logic [CW-1:0] C_TO_END   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] C_GAP_END  = CW'(GAP);

  state_t         r_state;
  logic [1:0]     r_last;
  logic [7:0]     r_addr;
  logic [72:0]    r_shift;
  logic [CW-1:0]  r_cnt;
  logic [3:0]     r_gnt;
  logic [3:0]     r_done;
  logic [7:0]     r_rsp_addr;
  logic [2:0]     r_rsp_op;
  logic [61:0]    r_rsp_data;
  logic           r_rsp_err;
  logic           r_busy;
  logic           r_tx;

  logic [1:0]     w_win;
  logic           w_any;
  logic [72:0]    w_cap;

  assign w_any = |req;
  // Reply frame as it stands once the current rx sample is shifted in
  assign w_cap = {r_shift[71:0], rx};

  // Round-robin pick: first requester after r_last, wrapping modulo 4
  always_comb begin
    w_win = r_last;
    for (int k = 4; k >= 1; k--) begin
      if (req[r_last + 2'(k)]) w_win = r_last + 2'(k);
    end
  end

  // Transaction FSM: grant, serialise, wait for reply, capture, enforce idle gap
  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      r_state    <= S_IDLE;
      r_last     <= 2'd3;
      r_addr     <= '0;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_rsp_addr <= '0;
      r_rsp_op   <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_busy     <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= 4'b0001 << w_win;
            r_last  <= w_win;
            r_addr  <= req_addr[8*w_win +: 8];
            r_shift <= {req_addr[8*w_win +: 8], req_op[3*w_win +: 3], req_data[62*w_win +: 62]};
            r_tx    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (r_cnt == C_SEND_END) begin
            r_tx    <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_WAIT_RSP;
          end else begin
            r_tx    <= r_shift[72];
            r_shift <= {r_shift[71:0], 1'b0};
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        S_WAIT_RSP: begin
          if (!rx) begin
            r_cnt   <= '0;
            r_state <= S_RECV;
          end else if (r_cnt == C_TO_END) begin
            r_done     <= 4'b0001 << r_last;
            r_rsp_addr <= '0;
            r_rsp_op   <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_GAP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RECV: begin
          r_shift <= w_cap;
          if (r_cnt == C_RECV_END) begin
            r_done     <= 4'b0001 << r_last;
            r_rsp_addr <= w_cap[72:65];
            r_rsp_op   <= w_cap[64:62];
            r_rsp_data <= w_cap[61:0];
            r_rsp_err  <= (w_cap[72:65] != r_addr);
            r_cnt      <= '0;
            r_state    <= S_GAP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (r_cnt == C_GAP_END) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign done     = r_done;
  assign rsp_addr = r_rsp_addr;
  assign rsp_op   = r_rsp_op;
  assign rsp_data = r_rsp_data;
  assign rsp_err  = r_rsp_err;
  assign busy     = r_busy;
  assign tx       = r_tx;

endmodule

// File: tb/tb_percept_bus_ctrl.sv
// tb/tb_percept_bus_ctrl.sv - self-checking bench for percept_bus_ctrl
module tb_percept_bus_ctrl;

  localparam int TIMEOUT = 256;
  localparam int GAP     = 4;
  localparam int BOUND   = 2000;

  logic         clk = 1'b0;
  logic         nRst;
  logic [3:0]   req;
  logic [31:0]  req_addr;
  logic [11:0]  req_op;
  logic [247:0] req_data;
  logic [3:0]   gnt;
  logic [3:0]   done;
  logic [7:0]   rsp_addr;
  logic [2:0]   rsp_op;
  logic [61:0]  rsp_data;
  logic         rsp_err;
  logic         busy;
  logic         tx;
  logic         rx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  percept_bus_ctrl #(.TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clk(clk), .nRst(nRst), .req(req), .req_addr(req_addr), .req_op(req_op),
    .req_data(req_data), .gnt(gnt), .done(done), .rsp_addr(rsp_addr),
    .rsp_op(rsp_op), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .tx(tx), .rx(rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Node model: capture a request frame from tx, then echo it on rx after node_dly clocks
  bit          node_en = 1'b0;
  bit          node_busy = 1'b0;
  int          node_dly = 10;
  bit          node_ovr = 1'b0;
  logic [7:0]  node_ovr_addr = 8'h00;
  logic [72:0] node_q[$];
  logic [72:0] nf;
  logic [72:0] nr;

  initial begin
    rx = 1'b1;
    forever begin
      @(negedge clk);
      if (node_en && tx === 1'b0 && nRst === 1'b0) begin
        node_busy = 1'b1;
        for (int i = 72; i >= 0; i--) begin
          @(negedge clk);
          nf[i] = tx;
        end
        node_q.push_back(nf);
        nr = nf;
        if (node_ovr) nr[72:65] = node_ovr_addr;
        repeat (node_dly) @(negedge clk);
        rx = 1'b0;
        for (int i = 72; i >= 0; i--) begin
          @(negedge clk);
          rx = nr[i];
        end
        @(negedge clk);
        rx = 1'b1;
        node_busy = 1'b0;
      end
    end
  end

  typedef struct {
    logic [3:0]  mask;
    logic [7:0]  addr;
    logic [2:0]  op;
    logic [61:0] data;
    int          dly;
    bit          ovr;
    logic [7:0]  ovr_addr;
    int          win;
    logic [7:0]  exp_addr;
    bit          exp_err;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int rr_pick(input logic [3:0] m, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (m[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic set_lane(input int k, input logic [7:0] a, input logic [2:0] o, input logic [61:0] d);
    req_addr[8*k +: 8]  = a;
    req_op[3*k +: 3]    = o;
    req_data[62*k +: 62] = d;
  endtask

  task automatic rand_lanes();
    for (int k = 0; k < 4; k++)
      set_lane(k, 8'($urandom), 3'($urandom), 62'({$urandom(), $urandom()}));
  endtask

  task automatic wait_gnt(output int idx, output int t);
    idx = -1;
    t = 0;
    for (int n = 0; n < BOUND; n++) begin
      @(negedge clk);
      if (gnt != 4'b0000) begin
        idx = oh_idx(gnt);
        t = cyc;
        chk("done_with_gnt", done, 0);
        chk("busy_at_gnt", busy, 1);
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL gnt_wait: no grant within %0d cycles", BOUND);
  endtask

  task automatic wait_done(output int idx, output int t, output logic [7:0] a,
                           output logic [2:0] o, output logic [61:0] d, output logic e);
    idx = -1; t = 0; a = '0; o = '0; d = '0; e = 1'b0;
    for (int n = 0; n < BOUND; n++) begin
      @(negedge clk);
      if (done != 4'b0000) begin
        idx = oh_idx(done);
        t = cyc;
        a = rsp_addr; o = rsp_op; d = rsp_data; e = rsp_err;
        chk("gnt_with_done", gnt, 0);
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL done_wait: no done within %0d cycles", BOUND);
  endtask

  task automatic wait_node_idle();
    for (int n = 0; n < BOUND; n++) begin
      if (!node_busy) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL node_idle_wait: node still busy after %0d cycles", BOUND);
  endtask

  task automatic chk_frame(input string name, input logic [72:0] exp);
    if (node_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no frame captured on tx, want %0h", name, exp);
    end else begin
      chk(name, node_q.pop_front(), exp);
    end
  endtask

  task automatic do_reset();
    req = 4'b0000;
    nRst = 1'b1;
    repeat (3) @(negedge clk);
    nRst = 1'b0;
    @(negedge clk);
  endtask

  // One full echoed transaction with the winner's payload on its lane and junk elsewhere
  task automatic run_txn(input string tag, input logic [3:0] mask, input int exp_win,
                         input logic [7:0] a, input logic [2:0] o, input logic [61:0] d,
                         input int dly, input bit ovr, input logic [7:0] oa,
                         input logic [7:0] exp_addr, input bit exp_err);
    int gi, tg, di, td;
    logic [7:0] ra;
    logic [2:0] ro;
    logic [61:0] rd;
    logic re;
    node_en = 1'b1;
    node_dly = dly;
    node_ovr = ovr;
    node_ovr_addr = oa;
    rand_lanes();
    set_lane(exp_win, a, o, d);
    req = mask;
    wait_gnt(gi, tg);
    chk($sformatf("%s winner", tag), gi, exp_win);
    req = 4'b0000;
    wait_done(di, td, ra, ro, rd, re);
    chk($sformatf("%s done_idx", tag), di, exp_win);
    chk($sformatf("%s latency", tag), td - tg, 147 + dly);
    chk($sformatf("%s rsp_addr", tag), ra, exp_addr);
    chk($sformatf("%s rsp_op", tag), ro, o);
    chk($sformatf("%s rsp_data", tag), rd, d);
    chk($sformatf("%s rsp_err", tag), re, exp_err);
    chk_frame($sformatf("%s tx_frame", tag), {a, o, d});
    wait_node_idle();
    @(negedge clk);
    chk($sformatf("%s rsp_hold", tag), {rsp_addr, rsp_data}, {exp_addr, d});
  endtask

  initial begin
    int gi, tg, di, td, tg2, nd, m_last, w, dl;
    logic [7:0] ra, a, oa;
    logic [2:0] ro, o;
    logic [61:0] rd, d;
    logic re;
    logic [3:0] m;
    bit ov;
    int ord[5];

    tbl[0] = '{4'b0001, 8'hAA, 3'h4, 62'd100,               10, 1'b0, 8'h00, 0, 8'hAA, 1'b0};
    tbl[1] = '{4'b0110, 8'h3C, 3'h7, 62'h3FFF_FFFF_FFFF_FFFF, 1, 1'b0, 8'h00, 1, 8'h3C, 1'b0};
    tbl[2] = '{4'b1101, 8'hAA, 3'h1, 62'h3,                  6, 1'b1, 8'h55, 2, 8'h55, 1'b1};
    tbl[3] = '{4'b1011, 8'h00, 3'h0, 62'h0,                  5, 1'b0, 8'h00, 3, 8'h00, 1'b0};
    tbl[4] = '{4'b1010, 8'hFF, 3'h1, 62'h2AAA_AAAA_AAAA_AAAA, 20, 1'b0, 8'h00, 1, 8'hFF, 1'b0};
    tbl[5] = '{4'b1001, 8'h80, 3'h6, 62'h1_0000_0001,        3, 1'b1, 8'h80, 3, 8'h80, 1'b0};

    req = 4'b0000;
    req_addr = '0;
    req_op = '0;
    req_data = '0;
    nRst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst tx", tx, 1);
    chk("rst gnt", gnt, 0);
    chk("rst done", done, 0);
    chk("rst busy", busy, 0);
    chk("rst rsp_addr", rsp_addr, 0);
    chk("rst rsp_op", rsp_op, 0);
    chk("rst rsp_data", rsp_data, 0);
    chk("rst rsp_err", rsp_err, 0);
    nRst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_txn($sformatf("vec%0d", i), tbl[i].mask, tbl[i].win, tbl[i].addr, tbl[i].op,
              tbl[i].data, tbl[i].dly, tbl[i].ovr, tbl[i].ovr_addr, tbl[i].exp_addr,
              tbl[i].exp_err);
    repeat (10) @(negedge clk);
    chk("idle busy", busy, 0);

    // Timeout with rx held high, then a waiting request must respect the idle gap
    node_en = 1'b0;
    rand_lanes();
    set_lane(2, 8'h11, 3'h2, 62'h1234);
    req = 4'b0100;
    wait_gnt(gi, tg);
    chk("to winner", gi, 2);
    req = 4'b0000;
    wait_done(di, td, ra, ro, rd, re);
    chk("to done_idx", di, 2);
    chk("to latency", td - tg, 74 + TIMEOUT);
    chk("to rsp_err", re, 1);
    chk("to rsp_addr", ra, 0);
    chk("to rsp_op", ro, 0);
    chk("to rsp_data", rd, 0);
    node_en = 1'b1;
    node_dly = 2;
    node_ovr = 1'b0;
    set_lane(0, 8'h21, 3'h3, 62'h99);
    req = 4'b0001;
    wait_gnt(gi, tg2);
    chk("gap winner", gi, 0);
    chk("gap idle_clocks", (tg2 - td - 1) >= GAP, 1);
    req = 4'b0000;
    wait_done(di, td, ra, ro, rd, re);
    chk("gap rsp_err", re, 0);
    chk("gap rsp_data", rd, 62'h99);
    chk_frame("gap tx_frame", {8'h21, 3'h3, 62'h99});
    wait_node_idle();

    // Start bit exactly at counter TIMEOUT-1 is captured; one clock later times out
    run_txn("edge_in", 4'b0010, 1, 8'h42, 3'h5, 62'h0F0F, TIMEOUT, 1'b0, 8'h00, 8'h42, 1'b0);
    node_dly = TIMEOUT + 1;
    set_lane(1, 8'h43, 3'h2, 62'h777);
    req = 4'b0010;
    wait_gnt(gi, tg);
    chk("edge_out winner", gi, 1);
    req = 4'b0000;
    wait_done(di, td, ra, ro, rd, re);
    chk("edge_out latency", td - tg, 74 + TIMEOUT);
    chk("edge_out rsp_err", re, 1);
    chk("edge_out rsp_data", rd, 0);
    chk_frame("edge_out tx_frame", {8'h43, 3'h2, 62'h777});
    wait_node_idle();

    // Reset during the opcode bits aborts the frame
    node_en = 1'b0;
    set_lane(1, 8'hC3, 3'b010, 62'h77);
    req = 4'b0010;
    wait_gnt(gi, tg);
    chk("rstmid winner", gi, 1);
    req = 4'b0000;
    repeat (9) @(negedge clk);
    chk("rstmid op_msb", tx, 0);
    nRst = 1'b1;
    #1;
    chk("rstmid tx", tx, 1);
    chk("rstmid busy", busy, 0);
    chk("rstmid gnt", gnt, 0);
    repeat (2) @(negedge clk);
    nRst = 1'b0;
    nd = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done != 4'b0000) nd++;
    end
    chk("rstmid no_done", nd, 0);
    run_txn("after_rst", 4'b0010, 1, 8'h5A, 3'h3, 62'h1_2345_6789, 4, 1'b0, 8'h00, 8'h5A, 1'b0);

    // Round-robin with all requesters held, then a two-requester mask
    do_reset();
    node_en = 1'b1;
    node_dly = 3;
    node_ovr = 1'b0;
    for (int k = 0; k < 4; k++) set_lane(k, 8'(16 + k), 3'(k), 62'(k + 1));
    ord = '{0, 1, 2, 3, 0};
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_gnt(gi, tg);
      chk($sformatf("rr%0d winner", j), gi, ord[j]);
      if (j == 4) req = 4'b1001;
      wait_done(di, td, ra, ro, rd, re);
      chk($sformatf("rr%0d done_idx", j), di, ord[j]);
      chk($sformatf("rr%0d rsp_addr", j), ra, 8'(16 + ord[j]));
      chk_frame($sformatf("rr%0d tx_frame", j), {8'(16 + ord[j]), 3'(ord[j]), 62'(ord[j] + 1)});
    end
    wait_gnt(gi, tg);
    chk("rr1001 winner", gi, 3);
    req = 4'b0000;
    wait_done(di, td, ra, ro, rd, re);
    chk("rr1001 done_idx", di, 3);
    chk_frame("rr1001 tx_frame", {8'(19), 3'(3), 62'(4)});
    wait_node_idle();

    // Randomised transactions against the round-robin/echo reference model
    do_reset();
    m_last = 3;
    for (int r = 0; r < 20; r++) begin
      m = 4'($urandom_range(1, 15));
      w = rr_pick(m, m_last);
      a = 8'($urandom);
      o = 3'($urandom);
      d = 62'({$urandom(), $urandom()});
      dl = $urandom_range(1, 30);
      ov = ($urandom_range(0, 3) == 0);
      oa = 8'($urandom);
      run_txn($sformatf("rnd%0d", r), m, w, a, o, d, dl, ov, oa, ov ? oa : a,
              ov && (oa != a));
      m_last = w;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/percept_bus_ctrl.md
Name: percept_bus_ctrl

Overview:
- Bus master for the perceptron node serial link.
- Accepts operation requests from four requesters and arbitrates them round-robin.
- Serialises the winner as one frame on tx (start bit, 8-bit address, 3-bit opcode, 62-bit data, one bit per clock).
- Captures the addressed node's reply frame on rx, or reports a timeout, then returns the result to the granted requester.

Parameters:
- TIMEOUT, 256: max clocks waited in WAIT_RSP for a reply start bit.
- GAP, 4: min idle-high clocks on tx between the end of one transaction and the next start bit.

Ports:
- clk  in  1  system clock.
- nRst  in  1  asynchronous, active-high reset (1 = reset asserted).
- req  in  4  request per requester; held high until granted.
- req_addr  in  32  packed 4x8, requester k in bits [8k+7:8k].
- req_op  in  12  packed 4x3, requester k in bits [3k+2:3k].
- req_data  in  248  packed 4x62, requester k in bits [62k+61:62k].
- gnt  out  4  one-hot, one-cycle pulse when a request is accepted.
- done  out  4  one-hot, one-cycle pulse to the granted requester when its transaction ends.
- rsp_addr  out  8  address field of the captured reply.
- rsp_op  out  3  opcode field of the captured reply.
- rsp_data  out  62  data field of the captured reply.
- rsp_err  out  1  valid with done: 1 = timeout or address mismatch.
- busy  out  1  high in every state except IDLE.
- tx  out  1  serial line to node rx; idles high.
- rx  in  1  serial line from node tx; idles high.

Behaviour:
- Reset (async, nRst=1):
  - tx=1; gnt=0, done=0, busy=0.
  - rsp_addr, rsp_op, rsp_data and rsp_err all 0.
  - Round-robin pointer last=3, so requester 0 has first priority.
  - State=IDLE; GAP counter treated as satisfied.
  - Reset mid-frame aborts the transaction: no done is issued and tx goes high immediately.
- States: IDLE, SEND, WAIT_RSP, RECV, GAP.
- IDLE:
  - In a cycle T with any req bit set, the controller picks the first set bit searching from last+1 upward, wrapping modulo 4.
  - On the edge ending T: latch that requester's addr/op/data, set last to the winner, and move to SEND.
  - gnt[winner]=1 and tx=0 (start bit) during T+1.
- SEND:
  - Bits are sent MSB first: addr during T+2..T+9, opcode during T+10..T+12, data during T+13..T+74.
  - Total frame is 74 bit-times.
  - tx=1 from T+75; state becomes WAIT_RSP at T+75.
  - rx is ignored during SEND.
- WAIT_RSP:
  - Wait counter starts at 0 at T+75 and increments each clock.
  - rx=0 sampled in any cycle → RECV. The start bit wins even in the cycle the counter equals TIMEOUT-1.
  - Counter reaching TIMEOUT with no start bit → done[winner] pulse next cycle.
  - Timeout result: rsp_err=1, rsp_addr/rsp_op/rsp_data=0. Then GAP.
- RECV:
  - The next 73 rx samples shift in MSB first as address(8), opcode(3), data(62).
  - In the cycle after the last sample, rsp_* update and done[winner] pulses.
  - rsp_err=1 if the captured address differs from the sent address; data is still reported.
  - Then GAP.
- GAP:
  - tx=1 for GAP clocks, counted from the cycle after done; then IDLE.
  - Requests arriving during GAP wait; none are granted until IDLE.
- Requests:
  - A requester dropping req before grant is simply not selected.
  - req inputs change nothing after grant; the frame uses the latched values.
- rsp_* registers hold their value until the next done. gnt and done never assert in the same cycle.

Test Plan:
- Single op, loopback node model echoing frame after 10 clocks:
  - Stimulus: req[0] with addr 8'hAA, op 3'h4, data 100.
  - Response: gnt[0] pulse; tx shows 0, 10101010, 100, 62-bit 100.
  - Response: done[0] with rsp_addr=AA, rsp_op=4, rsp_data=100, rsp_err=0.
- Timeout, rx held high:
  - Stimulus: req[2] with addr 8'h11.
  - Response: done[2] exactly TIMEOUT+1 clocks after frame end, rsp_err=1, rsp_data=0.
  - Response: next grant at least GAP clocks later.
- Round-robin:
  - Stimulus: req=4'b1111 held continuously after reset.
  - Response: grant order 0,1,2,3,0.
  - Stimulus: then req=4'b1001 with last=0.
  - Response: next grant goes to 3.
- Address mismatch:
  - Stimulus: node replies with addr 8'h55 to a frame sent to 8'hAA, data 62'h3.
  - Response: done with rsp_err=1, rsp_addr=55, rsp_data=3.
- Reset mid-frame:
  - Stimulus: assert nRst during opcode bits.
  - Response: tx=1 at once, no done, busy=0.
  - Stimulus: after release, a new req[1].
  - Response: gnt[1] with a full 74-bit frame.
- Start-bit/timeout boundary:
  - Stimulus: reply start bit in the cycle the counter equals TIMEOUT-1.
  - Response: reply captured, rsp_err=0.
  - Stimulus: reply start bit one cycle later.
  - Response: timeout.
